// File: rtl/dll_retry_monitor_if.sv
// Handshake bundle for dll_retry_monitor.
// slave: the retry buffer; master: TL/DLCMSM/arbiter side.
interface dll_retry_monitor_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    dlcm_state_i;
  logic          tl2dll_valid_i;
  logic [255:0]  tl2dll_data_i;
  logic          tl2dll_ready_o;
  logic [15:0]   acknak_seq_num_i;
  logic [1:0]    acknak_seq_en_i;
  logic          tlp_valid_o;
  logic [255:0]  tlp_data_o;
  logic [11:0]   tlp_seq_o;
  logic          arb_ready_i;
  logic          replay_rollover_o;
  logic [CW-1:0] buf_count_o;

  modport slave (
    input  dlcm_state_i,
    input  tl2dll_valid_i,
    input  tl2dll_data_i,
    output tl2dll_ready_o,
    input  acknak_seq_num_i,
    input  acknak_seq_en_i,
    output tlp_valid_o,
    output tlp_data_o,
    output tlp_seq_o,
    input  arb_ready_i,
    output replay_rollover_o,
    output buf_count_o
  );

  modport master (
    output dlcm_state_i,
    output tl2dll_valid_i,
    output tl2dll_data_i,
    input  tl2dll_ready_o,
    output acknak_seq_num_i,
    output acknak_seq_en_i,
    input  tlp_valid_o,
    input  tlp_data_o,
    input  tlp_seq_o,
    output arb_ready_i,
    input  replay_rollover_o,
    input  buf_count_o
  );
endinterface

// File: rtl/dll_retry_monitor.sv
// DLL transmit retry buffer: seq numbering, ACK/NAK purge, replay.
// Ports: sclk, srst (sync, active-high), bus (slave modport).
module dll_retry_monitor #(
  parameter int DEPTH          = 16,
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic               sclk,
  input  logic               srst,
  dll_retry_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(REPLAY_TIMEOUT - 1);

  typedef enum logic {
    NORMAL,
    REPLAY
  } state_t;

  state_t state, state_nx;

  logic [255:0] mem [DEPTH];

  logic [PW-1:0] head, head_nx;
  logic [PW-1:0] send, send_nx;
  logic [PW-1:0] tail, tail_nx;
  logic [PW-1:0] rend, rend_nx;
  logic [11:0]   ackd, ackd_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [1:0]    rnum, rnum_nx, rbase;
  logic          roll, roll_nx;

  logic          dl_active;
  logic          ready, valid;
  logic          acc, hs;
  logic [PW-1:0] count, sent, lim;
  logic [PW-1:0] n_p, send_adv, left;
  logic [11:0]   seq_in, n;
  logic          ack_ev, nak_ev;
  logic          in_win, purge, nak_ok, pass;
  logic          counting, tmo, rstart;
  logic          unused_hi;

  assign unused_hi = ^bus.acknak_seq_num_i[15:12];

  assign dl_active = bus.dlcm_state_i == 2'd3;
  assign count     = tail - head;
  assign sent      = send - head;

  // count never exceeds DEPTH, so its MSB alone flags "full"
  assign ready = ~srst & dl_active & ~count[PW-1]
               & (state == NORMAL);
  assign valid = ~srst & dl_active & (send != tail);

  assign acc = ready & bus.tl2dll_valid_i;
  assign hs  = valid & bus.arb_ready_i;

  assign seq_in = bus.acknak_seq_num_i[11:0];
  assign ack_ev = bus.acknak_seq_en_i == 2'b01;
  assign nak_ev = bus.acknak_seq_en_i == 2'b10;
  assign n      = seq_in - ackd;

  // While replaying, entries up to rend already went out
  // once, so they remain acknowledgeable.
  assign lim = (state == REPLAY) ? rend - head : sent;

  assign in_win = n <= 12'(lim);
  assign purge  = (ack_ev | nak_ev) & in_win & (n != 12'd0);
  assign nak_ok = nak_ev & in_win;
  assign n_p    = purge ? PW'(n) : '0;

  // same-cycle send handshake is applied after the purge
  assign pass     = n_p > sent;
  assign send_adv = pass ? head + n_p : send + PW'(hs);

  assign counting = (state == NORMAL) & (sent != '0);
  assign tmo      = counting & (timer == TLAST);

  always_comb begin
    head_nx  = head + n_p;
    tail_nx  = tail + PW'(acc);
    ackd_nx  = purge ? seq_in : ackd;
    left     = (state == REPLAY) ? rend - head_nx
                                 : send_adv - head_nx;
    rstart   = (nak_ok & (left != '0)) | (tmo & ~purge);
    send_nx  = rstart ? head_nx : send_adv;
    rend_nx  = (rstart & (state == NORMAL)) ? send_adv : rend;
    timer_nx = timer;
    if (rstart | purge) begin
      timer_nx = '0;
    end else if (counting) begin
      timer_nx = timer + TW'(1);
    end
    rbase   = purge ? 2'd0 : rnum;
    rnum_nx = rstart ? rbase + 2'd1 : rbase;
    roll_nx = rstart & (rbase == 2'd3);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      NORMAL: begin
        if (rstart) state_nx = REPLAY;
      end
      REPLAY: begin
        if (rstart) begin
          state_nx = REPLAY;
        end else if (send_nx == rend) begin
          state_nx = NORMAL;
        end
      end
      default: state_nx = NORMAL;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state <= NORMAL;
      head  <= '0;
      send  <= '0;
      tail  <= '0;
      rend  <= '0;
      ackd  <= 12'hFFF;
      timer <= '0;
      rnum  <= '0;
      roll  <= 1'b0;
    end else begin
      state <= state_nx;
      head  <= head_nx;
      send  <= send_nx;
      tail  <= tail_nx;
      rend  <= rend_nx;
      ackd  <= ackd_nx;
      timer <= timer_nx;
      rnum  <= rnum_nx;
      roll  <= roll_nx;
    end
  end

  always_ff @(posedge sclk) begin
    if (acc) begin
      mem[tail[AW-1:0]] <= bus.tl2dll_data_i;
    end
  end

  assign bus.tl2dll_ready_o    = ready;
  assign bus.tlp_valid_o       = valid;
  assign bus.tlp_data_o        = valid ? mem[send[AW-1:0]]
                                       : '0;
  assign bus.tlp_seq_o         = valid ? ackd + 12'd1 + 12'(sent)
                                       : 12'd0;
  assign bus.replay_rollover_o = roll & ~srst;
  assign bus.buf_count_o       = srst ? '0 : count;

endmodule

// File: tb/tb_dll_retry_monitor.sv
// Scoreboard bench for dll_retry_monitor.
// Stimulus pushes expected TLPs; a monitor pops on each handshake.
module tb_dll_retry_monitor;
  localparam int DEPTH = 16;
  localparam int TMO   = 64;

  typedef struct packed {
    logic [11:0]  seq;
    logic [255:0] data;
  } exp_t;

  logic sclk = 1'b0;
  logic srst = 1'b1;

  always #5 sclk = ~sclk;

  dll_retry_monitor_if #(.DEPTH(DEPTH)) bus ();

  dll_retry_monitor #(
    .DEPTH(DEPTH),
    .REPLAY_TIMEOUT(TMO)
  ) dut (
    .sclk(sclk),
    .srst(srst),
    .bus(bus)
  );

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [11:0] nts;
  logic [7:0]  salt;
  int          pulses;

  function automatic logic [255:0] mkd(logic [7:0] s,
                                       logic [11:0] q);
    return {8{s, 12'h05A, q}};
  endfunction

  task automatic chk(string nm, logic [255:0] act,
                     logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  always @(negedge sclk) begin
    if (!srst && bus.tlp_valid_o && bus.arb_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tlp actual seq=%0d required none",
                 bus.tlp_seq_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tlp_seq", 256'(bus.tlp_seq_o), 256'(mon_e.seq));
        chk("tlp_data", bus.tlp_data_o, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic push_exp(logic [11:0] s);
    exp_t e;
    e.seq  = s;
    e.data = mkd(salt, s);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    chk("queue_empty_before_reset", 256'(exp_q.size()), 256'(0));
    srst = 1'b1;
    bus.tl2dll_valid_i  = 1'b0;
    bus.acknak_seq_en_i = 2'b00;
    repeat (2) tick();
    srst = 1'b0;
    nts  = 12'd0;
  endtask

  task automatic send_tlp();
    logic ok;
    ok = 1'b0;
    bus.tl2dll_valid_i = 1'b1;
    bus.tl2dll_data_i  = mkd(salt, nts);
    for (int i = 0; i < 64; i++) begin
      @(negedge sclk);
      if (bus.tl2dll_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok) begin
      push_exp(nts);
      nts = nts + 12'd1;
    end else begin
      errors++;
      $display("FAIL accept_timeout actual=no_ready required=ready seq=%0d",
               nts);
    end
    tick();
    bus.tl2dll_valid_i = 1'b0;
  endtask

  task automatic acknak(logic [1:0] en, logic [11:0] s);
    bus.acknak_seq_num_i = {4'hF, s};
    bus.acknak_seq_en_i  = en;
    tick();
    bus.acknak_seq_en_i  = 2'b00;
    bus.acknak_seq_num_i = 16'd0;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sclk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0",
               exp_q.size());
    end
    tick();
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_ready"}, 256'(bus.tl2dll_ready_o), 256'(0));
    chk({tag, "_valid"}, 256'(bus.tlp_valid_o), 256'(0));
    chk({tag, "_data"}, bus.tlp_data_o, 256'(0));
    chk({tag, "_seq"}, 256'(bus.tlp_seq_o), 256'(0));
    chk({tag, "_roll"}, 256'(bus.replay_rollover_o), 256'(0));
    chk({tag, "_count"}, 256'(bus.buf_count_o), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bus.dlcm_state_i     = 2'd3;
    bus.tl2dll_valid_i   = 1'b0;
    bus.tl2dll_data_i    = '0;
    bus.acknak_seq_num_i = 16'd0;
    bus.acknak_seq_en_i  = 2'b00;
    bus.arb_ready_i      = 1'b0;
    salt = 8'h00;
    nts  = 12'd0;

    // reset state
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    chk_zero_outputs("reset");
    tick();
    srst = 1'b0;
    @(negedge sclk);
    chk("ready_after_reset", 256'(bus.tl2dll_ready_o), 256'(1));
    tick();

    // basic flow
    salt = 8'h11;
    bus.arb_ready_i = 1'b1;
    repeat (3) send_tlp();
    drain();
    @(negedge sclk);
    chk("basic_count3", 256'(bus.buf_count_o), 256'(3));
    tick();
    acknak(2'b01, 12'd1);
    @(negedge sclk);
    chk("basic_ack1_count", 256'(bus.buf_count_o), 256'(1));
    tick();
    acknak(2'b01, 12'd2);
    @(negedge sclk);
    chk("basic_ack2_count", 256'(bus.buf_count_o), 256'(0));
    chk("basic_idle_valid", 256'(bus.tlp_valid_o), 256'(0));
    tick();

    // link down blocks acceptance
    bus.dlcm_state_i   = 2'd2;
    bus.tl2dll_valid_i = 1'b1;
    @(negedge sclk);
    chk("linkdown_ready", 256'(bus.tl2dll_ready_o), 256'(0));
    tick();
    bus.tl2dll_valid_i = 1'b0;
    bus.dlcm_state_i   = 2'd3;

    // full buffer
    do_reset();
    salt = 8'h22;
    bus.arb_ready_i = 1'b0;
    repeat (DEPTH) send_tlp();
    @(negedge sclk);
    chk("full_count", 256'(bus.buf_count_o), 256'(16));
    tick();
    bus.tl2dll_valid_i = 1'b1;
    bus.tl2dll_data_i  = mkd(salt, 12'd16);
    repeat (4) begin
      @(negedge sclk);
      chk("full_ready_low", 256'(bus.tl2dll_ready_o), 256'(0));
    end
    tick();
    bus.tl2dll_valid_i = 1'b0;
    acknak(2'b01, 12'd0);
    @(negedge sclk);
    chk("full_unsent_ack_ignored", 256'(bus.buf_count_o), 256'(16));
    tick();
    bus.arb_ready_i = 1'b1;
    drain();
    acknak(2'b01, 12'd15);
    @(negedge sclk);
    chk("full_ack15_count", 256'(bus.buf_count_o), 256'(0));
    chk("full_ready_back", 256'(bus.tl2dll_ready_o), 256'(1));
    tick();

    // NAK replay
    do_reset();
    salt = 8'h33;
    bus.arb_ready_i = 1'b1;
    repeat (5) send_tlp();
    drain();
    for (int s = 2; s <= 4; s++) push_exp(12'(s));
    acknak(2'b10, 12'd1);
    @(negedge sclk);
    chk("nak_ready_low", 256'(bus.tl2dll_ready_o), 256'(0));
    chk("nak_count", 256'(bus.buf_count_o), 256'(3));
    drain();
    @(negedge sclk);
    chk("nak_ready_normal", 256'(bus.tl2dll_ready_o), 256'(1));
    tick();

    // timeout and rollover
    do_reset();
    salt = 8'h44;
    bus.arb_ready_i = 1'b1;
    send_tlp();
    repeat (4) push_exp(12'd0);
    pulses = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sclk);
      if (bus.replay_rollover_o) pulses++;
      if (exp_q.size() == 0) break;
    end
    chk("tmo_queue_done", 256'(exp_q.size()), 256'(0));
    chk("tmo_rollover_pulses", 256'(pulses), 256'(1));
    tick();
    acknak(2'b01, 12'd0);
    @(negedge sclk);
    chk("tmo_ack_count", 256'(bus.buf_count_o), 256'(0));
    chk("tmo_roll_low", 256'(bus.replay_rollover_o), 256'(0));
    tick();

    // sequence wrap and invalid ACK
    do_reset();
    salt = 8'h55;
    bus.arb_ready_i = 1'b1;
    while (nts != 12'd4094) begin
      int k;
      k = 4094 - int'(nts);
      if (k > 14) k = 14;
      repeat (k) send_tlp();
      drain();
      acknak(2'b01, nts - 12'd1);
    end
    @(negedge sclk);
    chk("wrap_preload_count", 256'(bus.buf_count_o), 256'(0));
    tick();
    repeat (3) send_tlp();
    drain();
    acknak(2'b01, 12'd5);
    @(negedge sclk);
    chk("wrap_invalid_ack", 256'(bus.buf_count_o), 256'(3));
    tick();
    acknak(2'b01, 12'd0);
    @(negedge sclk);
    chk("wrap_ack0_count", 256'(bus.buf_count_o), 256'(0));
    tick();

    // reset mid-replay
    do_reset();
    salt = 8'h66;
    bus.arb_ready_i = 1'b1;
    repeat (3) send_tlp();
    drain();
    bus.arb_ready_i = 1'b0;
    acknak(2'b10, 12'hFFF);
    @(negedge sclk);
    chk("mid_replay_valid", 256'(bus.tlp_valid_o), 256'(1));
    chk("mid_replay_seq", 256'(bus.tlp_seq_o), 256'(0));
    chk("mid_replay_ready", 256'(bus.tl2dll_ready_o), 256'(0));
    tick();
    srst = 1'b1;
    tick();
    @(negedge sclk);
    chk_zero_outputs("midrst");
    tick();
    srst = 1'b0;
    nts  = 12'd0;
    @(negedge sclk);
    chk("midrst_count_after", 256'(bus.buf_count_o), 256'(0));
    chk("midrst_valid_after", 256'(bus.tlp_valid_o), 256'(0));
    tick();
    bus.arb_ready_i = 1'b1;
    send_tlp();
    drain();
    acknak(2'b01, 12'd0);
    @(negedge sclk);
    chk("midrst_final_count", 256'(bus.buf_count_o), 256'(0));
    chk("final_queue_empty", 256'(exp_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dll_retry_monitor.md
# dll_retry_monitor

Transmit-side Data Link Layer retry buffer, downstream of the DLL receive path. It accepts TLP beats from the Transaction Layer and assigns each one a 12-bit sequence number. Every transmitted TLP is held until the receive path reports an ACK covering it on `acknak_seq_num`/`acknak_seq_en`. A NAK or a replay-timer expiry replays all unacknowledged TLPs, in order, towards the TX arbiter.

## Interface
- `DEPTH` — default 16 — retry buffer entries, one 256-bit TLP beat each; power of 2, at most 2048.
- `REPLAY_TIMEOUT` — default 1024 — replay timer expiry, in `sclk` cycles.
- `sclk` — in — 1 — clock.
- `srst` — in — 1 — reset. Synchronous and active-high. The block uses one clock.
- `dlcm_state_i` — in — 2 — link state from the DLCMSM; `2'd3` is DL_Active.
- `tl2dll_valid_i` — in — 1 — TL has a TLP beat.
- `tl2dll_data_i` — in — 256 — TLP beat.
- `tl2dll_ready_o` — out — 1 — block accepts the beat this cycle.
- `acknak_seq_num_i` — in — 16 — ACK/NAK sequence number; `[11:0]` is used, `[15:12]` is ignored.
- `acknak_seq_en_i` — in — 2 — `2'b01` is ACK, `2'b10` is NAK; `00` and `11` mean no event.
- `tlp_valid_o` — out — 1 — TLP offered to the arbiter.
- `tlp_data_o` — out — 256 — TLP beat.
- `tlp_seq_o` — out — 12 — sequence number of the offered TLP.
- `arb_ready_i` — in — 1 — arbiter takes the TLP.
- `replay_rollover_o` — out — 1 — single-cycle pulse on REPLAY_NUM rollover.
- `buf_count_o` — out — log2(DEPTH)+1 — entries currently held.

## Operation
- **State:**
  - Pointers `head` (oldest unacked), `send` (next to transmit) and `tail` (next write) are each log2(DEPTH)+1 bits.
  - `NTS` (next transmit seq) resets to 0; `ACKD` (last acked seq) resets to 4095.
  - Sequence numbers are modulo 4096. Entry at `head`+k carries seq `ACKD`+1+k.
- **Accept:**
  - `tl2dll_ready_o` = DL_Active & (count < DEPTH) & (FSM == NORMAL).
  - On valid&ready: write `mem[tail]`, `tail++`, `NTS++`.
- **Transmit:**
  - `tlp_valid_o` = DL_Active & (`send` != `tail`) & (FSM == REPLAY, or `send` != `tail`).
  - `tlp_data_o` = `mem[send]`; `tlp_seq_o` = `ACKD`+1+(`send`-`head`).
  - On valid&arb_ready: `send++`.
- **ACK:**
  - n = (seq − `ACKD`) mod 4096.
  - If 0 < n ≤ (`send`-`head`): `head` += n, `ACKD` = seq, timer cleared, REPLAY_NUM cleared.
  - n == 0 is a duplicate; no purge.
  - n > sent count is invalid and ignored entirely.
- **NAK:** purge exactly as for ACK (a valid seq, or n == 0). Then, if any sent-unacked entries remain, start a replay.
- **Replay timer:**
  - Counts while (`send`-`head`) > 0 and FSM == NORMAL.
  - Cleared on a purging ACK/NAK and on replay start.
  - Reaching `REPLAY_TIMEOUT` starts a replay.
- **Replay start:**
  - `replay_end` = `send`, `send` = `head`, FSM → REPLAY.
  - REPLAY_NUM (2-bit) increments. On a 3→0 wrap, `replay_rollover_o` pulses; the replay still proceeds.
- **FSM:**
  - NORMAL → REPLAY on replay start.
  - REPLAY → NORMAL in the cycle after the handshake of the entry at `replay_end`−1.
  - REPLAY → NORMAL immediately if a purge leaves `head` ≥ `replay_end`.
- **NAK or timeout during REPLAY:** restarts the replay from the current `head`. `replay_end` is unchanged.
- **Purge passing `send`:** if the purge moves `head` past `send`, set `send` = `head`.
- **Link down:** DL_Active low blocks both handshakes; buffer contents and pointers are held.

## Timing
- **Reset values:**
  - Outputs while `srst` is high: `tl2dll_ready_o`=0, `tlp_valid_o`=0, `tlp_data_o`=0, `tlp_seq_o`=0, `replay_rollover_o`=0, `buf_count_o`=0.
  - FSM=NORMAL, timer=0, REPLAY_NUM=0.
- **Latency:**
  - An accepted TLP is offered (`tlp_valid_o`) in the cycle after acceptance.
  - Outputs are combinational from registered pointers and memory.
- **ACK/NAK latency:**
  - `acknak_seq_en_i` is sampled at the edge; the purge is visible at the next cycle.
  - Replay data appears the cycle after the NAK is sampled.
- **Same-cycle ordering:**
  - ACK/NAK applies to entries sent before the current cycle; a same-cycle send handshake is applied after the purge.
  - A same-cycle accept and purge both take effect, and `buf_count_o` reflects the net change.
  - Timer expiry and NAK in the same cycle produce one replay and one REPLAY_NUM increment.
  - Timer expiry in the same cycle as a purging ACK: the ACK wins and no replay occurs.
- **Mid-operation reset:** reset clears all state within one cycle; buffered TLPs are discarded.

## Test plan
- **Basic flow:** DL_Active; send 3 TLPs with `arb_ready_i`=1 → `tlp_seq_o` = 0, 1, 2. Then ACK seq 1 → `buf_count_o` goes 3→1. Then ACK seq 2 → count 0, timer stops.
- **Full buffer:** DEPTH=16, `arb_ready_i`=0; offer 17 TLPs → ready drops after the 16th. ACK is ignored (nothing sent). Set `arb_ready_i`=1, send all, ACK 15 → ready returns.
- **NAK replay:** send seq 0–4, NAK seq 1 → purge 0–1, replay seq 2, 3, 4, then NORMAL. `tl2dll_ready_o` stays 0 during the replay.
- **Timeout and rollover:** send seq 0, no ACK. Expiry at `REPLAY_TIMEOUT` replays seq 0, four times. The 4th start pulses `replay_rollover_o` for exactly 1 cycle.
- **Wrap and invalid ACK:** preload `NTS`=4094 via 4094 ACKed sends; next TLPs carry seq 4094, 4095, 0. ACK 0 purges all 3; an ACK with n > sent count is ignored.
- **Reset mid-replay:** assert `srst` during a replay → all outputs 0 next cycle. After release, the first TLP carries seq 0.
